uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx` serializer between `NUM_REQ` byte-stream requesters (memory dump, status reporter, echo path, etc.). It sits between the requesters and the `uart_tx` instance, issuing one `i_Tx_DV` pulse per byte and waiting for `o_Tx_Done` before arbitrating again. Optional burst locking keeps a multi-byte message from one requester contiguous on the serial line, bounded by `MAX_BURST` so no requester starves.

---
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte
// streams. It issues one tx_dv pulse per byte and waits for tx_done before the
// next decision. Optional burst locking keeps a message contiguous, bounded by
// MAX_BURST.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_byte,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_dv,
  output logic [7:0]           tx_byte,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_DONE, S_GAP} state_e;

  state_e               state_q, state_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 busy_q, busy_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic                 lock_q, lock_d;
  logic [ID_W-1:0]      lock_id_q, lock_id_d;
  logic [7:0]           burst_cnt_q, burst_cnt_d;

  // Decision signals shared by the next-state and output processes.
  logic                 decide;
  logic                 lock_hit;
  logic                 grant;
  logic [ID_W-1:0]      grant_k;
  logic [ID_W:0]        cand_sum;
  logic [ID_W-1:0]      cand;
  logic [7:0]           burst_new;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= '0;
      req_ready_q <= '0;
      grant_id_q  <= '0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
      burst_cnt_q <= '0;
    end else begin
      // NOTE: flops take non-blocking assignments so every register samples the pre-edge values.
      state_q     <= state_d;
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      req_ready_q <= req_ready_d;
      grant_id_q  <= grant_id_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Pick the requester to grant: locked owner first, else first valid from ptr.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    decide   = (state_q == S_IDLE) && !tx_active;
    lock_hit = lock_q && req_valid[lock_id_q];
    grant    = 1'b0;
    grant_k  = '0;
    cand_sum = '0;
    cand     = '0;
    if (decide) begin
      if (lock_hit) begin
        grant   = 1'b1;
        grant_k = lock_id_q;
      end else begin
        // Walk downward so the lowest offset from ptr wins the final overwrite.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
          cand_sum = {1'b0, ptr_q} + (ID_W + 1)'(i);
          if (cand_sum >= (ID_W + 1)'(NUM_REQ)) cand_sum = cand_sum - (ID_W + 1)'(NUM_REQ);
          cand = cand_sum[ID_W-1:0];
          if (req_valid[cand]) begin
            grant   = 1'b1;
            grant_k = cand;
          end
        end
      end
    end
    burst_new = lock_hit ? burst_cnt_q + 8'd1 : 8'd1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (grant) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_done) state_d = S_GAP;
      S_GAP:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Registered outputs, round-robin pointer and burst lock bookkeeping.
  always_comb begin
    tx_dv_d     = 1'b0;
    req_ready_d = '0;
    tx_byte_d   = tx_byte_q;
    grant_id_d  = grant_id_q;
    busy_d      = busy_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
    burst_cnt_d = burst_cnt_q;
    // A decision that cannot use the lock drops it, even if nothing is granted.
    if (decide && !lock_hit) lock_d = 1'b0;
    if (grant) begin
      tx_dv_d     = 1'b1;
      req_ready_d = NUM_REQ'(1) << grant_k;
      tx_byte_d   = req_byte[{grant_k, 3'b000} +: 8];
      grant_id_d  = grant_k;
      busy_d      = 1'b1;
      ptr_d       = (grant_k == ID_W'(NUM_REQ - 1)) ? '0 : grant_k + ID_W'(1);
      burst_cnt_d = burst_new;
      lock_d      = !req_last[grant_k] && (burst_new < 8'(MAX_BURST));
      lock_id_d   = grant_k;
    end
    if (state_q == S_GAP) busy_d = 1'b0;
  end

  assign tx_dv     = tx_dv_q;
  assign tx_byte   = tx_byte_q;
  assign req_ready = req_ready_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a table of single-decision vectors,
// hand-written multi-byte sequences, and randomized message sets compared
// against a queue-level round-robin/burst-lock model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_byte = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           tx_dv;
  logic [7:0]     tx_byte;
  logic           tx_active = 1'b0;
  logic           tx_done = 1'b0;
  logic [1:0]     grant_id;
  logic           busy;

  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(2), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_byte(req_byte),
    .req_last(req_last), .req_ready(req_ready), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .tx_active(tx_active), .tx_done(tx_done), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Requester byte queues: {last, byte}. Observed / expected grants: {id, byte}.
  logic [8:0] rq [N][$];
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];

  bit         spacing_chk = 1'b0;
  bit         have_done = 1'b0;
  bit         prev_dv = 1'b0;
  int         cyc = 0;
  int         last_done_cyc = 0;
  int         stub_cnt = 0;
  logic [7:0] stub_byte = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor, uart_tx stand-in and requesters, all updated on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (tx_dv) begin
      obs_q.push_back({grant_id, tx_byte});
      check("ready_onehot", 32'(req_ready), 32'(1) << grant_id);
      check("busy_on_grant", 32'(busy), 32'd1);
      check("dv_single_cycle", 32'(prev_dv), 32'd0);
      if (spacing_chk && have_done) check("b2b_spacing", cyc - last_done_cyc, 32'd3);
    end else if (req_ready != '0) begin
      check("ready_without_dv", 32'(req_ready), 32'd0);
    end
    prev_dv = tx_dv;

    if (tx_dv) begin
      stub_byte = tx_byte;
      tx_active = 1'b1;
      tx_done   = 1'b0;
      stub_cnt  = int'($urandom_range(2, 6));
    end else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        tx_active = 1'b0;
        tx_done   = 1'b1;
        if (busy) check("tx_byte_stable", 32'(tx_byte), 32'(stub_byte));
        last_done_cyc = cyc;
        have_done = 1'b1;
      end else begin
        tx_done = 1'b0;
      end
    end else begin
      tx_done = 1'b0;
    end

    for (int k = 0; k < N; k++) begin
      if (req_ready[k] && rq[k].size() > 0) void'(rq[k].pop_front());
      if (rq[k].size() > 0) begin
        req_valid[k]       = 1'b1;
        req_byte[8*k +: 8] = rq[k][0][7:0];
        req_last[k]        = rq[k][0][8];
      end else begin
        req_valid[k] = 1'b0;
      end
    end
  end

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += rq[k].size();
    return s;
  endfunction

  task automatic push_req(input int k, input logic [7:0] b, input logic last);
    rq[k].push_back({last, b});
  endtask

  task automatic push_exp(input int k, input logic [7:0] b);
    exp_q.push_back({2'(k), b});
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < N; k++) rq[k].delete();
    obs_q.delete();
    exp_q.delete();
    have_done   = 1'b0;
    spacing_chk = 1'b0;
    @(negedge clk); #1;
    check("reset_tx_dv", 32'(tx_dv), 32'd0);
    check("reset_tx_byte", 32'(tx_byte), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_grant_id", 32'(grant_id), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || tx_active || tx_dv) && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 2000) check({name, "_idle_timeout"}, {30'd0, busy, tx_active}, 32'd0);
  endtask

  // Let the requesters drain, then compare the grant log with the expectation.
  task automatic run_q(input string name);
    int n = 0;
    spacing_chk = 1'b1;
    while ((pending() > 0 || busy || tx_active) && n < 20000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 20000) check({name, "_timeout"}, pending() + 32'(busy), 32'd0);
    spacing_chk = 1'b0;
    check({name, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_item%0d", name, i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  // Queue-level reference: serve messages from the requester queues following
  // the round-robin and burst-lock rules, producing the expected grant order.
  task automatic build_expected();
    logic [8:0] m [N][$];
    logic [8:0] e;
    int ptr = 0, lid = 0, cnt = 0, k, total;
    bit lock = 1'b0;
    for (int i = 0; i < N; i++) m[i] = rq[i];
    exp_q.delete();
    total = pending();
    while (total > 0) begin
      if (lock && m[lid].size() > 0) begin
        k = lid;
        cnt++;
      end else begin
        cnt = 1;
        k = -1;
        for (int i = 0; i < N; i++)
          if (k < 0 && m[(ptr + i) % N].size() > 0) k = (ptr + i) % N;
      end
      e = m[k].pop_front();
      push_exp(k, e[7:0]);
      ptr  = (k + 1) % N;
      lock = !e[8] && (cnt < MB);
      lid  = k;
      total--;
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] bytes;
    logic [1:0]  exp_id;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n;
    int stray;
    tbl[0] = '{4'b0001, 32'h0000_00A5, 2'd0, 8'hA5};
    tbl[1] = '{4'b1111, 32'h4332_2110, 2'd1, 8'h21};
    tbl[2] = '{4'b1111, 32'h4332_2110, 2'd2, 8'h32};
    tbl[3] = '{4'b1111, 32'h4332_2110, 2'd3, 8'h43};
    tbl[4] = '{4'b1111, 32'h4332_2110, 2'd0, 8'h10};
    tbl[5] = '{4'b0001, 32'h0000_00C1, 2'd0, 8'hC1};
    tbl[6] = '{4'b1001, 32'hD300_00D0, 2'd3, 8'hD3};
    tbl[7] = '{4'b0110, 32'h00E2_E100, 2'd1, 8'hE1};
    tbl[8] = '{4'b0011, 32'h0000_F1F0, 2'd0, 8'hF0};
    tbl[9] = '{4'b0100, 32'h00A2_0000, 2'd2, 8'hA2};

    repeat (2) @(negedge clk);
    do_reset();

    // Single decisions: exact grant latency, pointer order and wrap-around.
    foreach (tbl[i]) begin
      wait_idle("tbl");
      for (int k = 0; k < N; k++)
        if (tbl[i].valid[k]) push_req(k, tbl[i].bytes[8*k +: 8], 1'b1);
      @(negedge clk); #1;
      check($sformatf("tbl%0d_early_dv", i), 32'(tx_dv), 32'd0);
      @(negedge clk); #1;
      check($sformatf("tbl%0d_dv", i), 32'(tx_dv), 32'd1);
      check($sformatf("tbl%0d_grant_id", i), 32'(grant_id), 32'(tbl[i].exp_id));
      check($sformatf("tbl%0d_tx_byte", i), 32'(tx_byte), 32'(tbl[i].exp_byte));
      check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(1) << tbl[i].exp_id);
      for (int k = 0; k < N; k++) rq[k].delete();
      @(negedge clk); #1;
      check($sformatf("tbl%0d_pulse_end", i), {27'd0, tx_dv, req_ready}, 32'd0);
    end
    wait_idle("tbl_end");

    // Round-robin with refill.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push_req(0, 8'h10, 1'b1); push_req(1, 8'h21, 1'b1);
      push_req(2, 8'h32, 1'b1); push_req(3, 8'h43, 1'b1);
      push_exp(0, 8'h10); push_exp(1, 8'h21); push_exp(2, 8'h32); push_exp(3, 8'h43);
    end
    run_q("rr");

    // Burst lock keeps req1's message contiguous.
    do_reset();
    push_req(1, 8'h01, 1'b0); push_req(1, 8'h02, 1'b0); push_req(1, 8'h03, 1'b1);
    push_req(2, 8'h77, 1'b1);
    push_exp(1, 8'h01); push_exp(1, 8'h02); push_exp(1, 8'h03); push_exp(2, 8'h77);
    run_q("burst");

    // MAX_BURST bounds the lock.
    do_reset();
    for (int b = 0; b < 6; b++) push_req(0, 8'(b), 1'b0);
    push_req(3, 8'hEE, 1'b1);
    for (int b = 0; b < 4; b++) push_exp(0, 8'(b));
    push_exp(3, 8'hEE); push_exp(0, 8'h04); push_exp(0, 8'h05);
    run_q("maxburst");

    // Lock released when the owner drops valid.
    do_reset();
    push_req(1, 8'h11, 1'b0);
    push_req(2, 8'h55, 1'b1);
    push_req(3, 8'h66, 1'b1);
    push_exp(1, 8'h11); push_exp(2, 8'h55); push_exp(3, 8'h66);
    run_q("release");

    // Reset while a byte is on the line.
    do_reset();
    push_req(0, 8'hAB, 1'b1);
    push_req(1, 8'hCD, 1'b1);
    n = 0;
    while (!tx_dv && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("rstmid_first_grant", {22'd0, grant_id, tx_byte}, {22'd0, 2'd0, 8'hAB});
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("rstmid_tx_dv", 32'(tx_dv), 32'd0);
    check("rstmid_tx_byte", 32'(tx_byte), 32'd0);
    check("rstmid_req_ready", 32'(req_ready), 32'd0);
    check("rstmid_grant_id", 32'(grant_id), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    n = 0;
    stray = 0;
    while (tx_active && n < 100) begin
      if (tx_dv) stray++;
      @(negedge clk); #1;
      n++;
    end
    check("rstmid_no_dv_while_active", stray + 32'(tx_dv), 32'd0);
    @(negedge clk); #1;
    check("rstmid_regrant_dv", 32'(tx_dv), 32'd1);
    check("rstmid_regrant", {22'd0, grant_id, tx_byte}, {22'd0, 2'd1, 8'hCD});
    wait_idle("rstmid");

    // Randomized message sets against the queue-level model.
    for (int round = 0; round < 6; round++) begin
      do_reset();
      for (int k = 0; k < N; k++) begin
        int nmsg = int'($urandom_range(0, 3));
        for (int m = 0; m < nmsg; m++) begin
          int len = int'($urandom_range(1, 6));
          for (int b = 0; b < len; b++) push_req(k, 8'($urandom), b == len - 1);
        end
      end
      build_expected();
      run_q($sformatf("rand%0d", round));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
